// File: rtl/tiny_ifft.sv
// 4-point inverse FFT receiver: locks to the serialized spectrum stream and emits 4 time samples (x/4, truncated).
// Latency: sample 0 is valid one cycle after word 7 of a frame is accepted.
// Backpressure: none on the input side; out_ready stalls only the output buffer, and a frame completing while the buffer is busy is dropped (ovf).
// Optional: define TINY_IFFT_CHECK_EN to flag spectra that cannot come from a real 4-point signal (reported on sync_err).
module tiny_ifft #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic                    in_re,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic [1:0]              out_idx,
  output logic                    out_last,
  output logic                    locked,
  output logic                    sync_err,
  output logic                    ovf
);

  // Two guard bits so a sum of four operands can never overflow.
  localparam int SW = IN_W + 2;

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] CAPTURE = 1'b1;

  logic [0:0]              state;
  logic [2:0]              cnt;
  logic signed [IN_W-1:0]  w [0:7];

  logic signed [OUT_W-1:0] samp [0:3];
  logic                    busy;
  logic [1:0]              idx;

  logic frame_start;
  logic restart;
  logic bad;
  logic store;
  logic frame_done;
  logic chk_fail;

  logic signed [SW-1:0]    e0r, e1r, e1i, e2r, e3r, e3i;
  logic signed [SW-1:0]    s  [0:3];
  logic signed [SW-1:0]    sh [0:3];
  logic signed [OUT_W-1:0] x  [0:3];

  logic xfer;
  logic xfer_last;
  logic buf_free;

  function automatic logic signed [SW-1:0] sx(input logic signed [IN_W-1:0] v);
    return {{2{v[IN_W-1]}}, v};
  endfunction

  // Classify the incoming word: start of frame, restart, framing error or ordinary store.
  always_comb begin
    frame_start = 1'b0;
    restart     = 1'b0;
    bad         = 1'b0;
    store       = 1'b0;
    if (in_valid) begin
      if (state == HUNT) begin
        frame_start = in_sof;
      end else if (in_sof && cnt != 3'd0) begin
        restart     = 1'b1;
        frame_start = 1'b1;
      end else if ((in_re != ~cnt[0]) || (cnt == 3'd0 && !in_sof)) begin
        bad = 1'b1;
      end else begin
        store = 1'b1;
      end
    end
  end

  assign frame_done = store && (cnt == 3'd7);

  // Inverse DFT on the completing frame; word 7 (X3i) is taken straight from the input.
  always_comb begin
    e0r = sx(w[0]);
    e1r = sx(w[2]);
    e1i = sx(w[3]);
    e2r = sx(w[4]);
    e3r = sx(w[6]);
    e3i = sx(in_data);
    s[0] = e0r + e2r + e1r + e3r;
    s[1] = e0r - e2r - e1i + e3i;
    s[2] = e0r + e2r - e1r - e3r;
    s[3] = e0r - e2r + e1i - e3i;
    for (int n = 0; n < 4; n++) begin
      sh[n] = s[n] >>> 2;
      x[n]  = sh[n][OUT_W-1:0];
    end
  end

`ifdef TINY_IFFT_CHECK_EN
  // A real time signal has purely real DC/Nyquist bins, conjugate-symmetric X1/X3 and sums divisible by 4.
  assign chk_fail = frame_done &&
                    ((w[1] != '0) || (w[5] != '0) ||
                     (e1r != e3r) || (e1i != -e3i) ||
                     ((s[0][1:0] | s[1][1:0] | s[2][1:0] | s[3][1:0]) != 2'b00));
`else
  assign chk_fail = 1'b0;
`endif

  // Frame sync state machine and word capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= HUNT;
      cnt    <= 3'd0;
      locked <= 1'b0;
      for (int i = 0; i < 8; i++) w[i] <= '0;
    end else if (frame_start) begin
      w[0]   <= in_data;
      cnt    <= 3'd1;
      state  <= CAPTURE;
      locked <= 1'b1;
    end else if (bad) begin
      state  <= HUNT;
      cnt    <= 3'd0;
      locked <= 1'b0;
    end else if (store) begin
      w[cnt] <= in_data;
      cnt    <= cnt + 3'd1;
    end
  end

  assign xfer      = busy && out_ready;
  assign xfer_last = xfer && (idx == 2'd3);
  // The buffer can take a new frame if empty or if its last sample leaves this cycle.
  assign buf_free  = !busy || xfer_last;

  // Output buffer, handshake and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      idx      <= 2'd0;
      sync_err <= 1'b0;
      ovf      <= 1'b0;
      for (int i = 0; i < 4; i++) samp[i] <= '0;
    end else begin
      sync_err <= restart || bad || chk_fail;
      ovf      <= frame_done && !buf_free;
      if (frame_done && buf_free) begin
        for (int i = 0; i < 4; i++) samp[i] <= x[i];
        busy <= 1'b1;
        idx  <= 2'd0;
      end else if (xfer_last) begin
        busy <= 1'b0;
        idx  <= 2'd0;
      end else if (xfer) begin
        idx <= idx + 2'd1;
      end
    end
  end

  assign out_valid = busy;
  assign out_idx   = idx;
  assign out_data  = busy ? samp[idx] : '0;
  assign out_last  = busy && (idx == 2'd3);

endmodule

// File: tb/tb_tiny_ifft.sv
module tb_tiny_ifft;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_sof;
  logic              in_re;
  logic signed [5:0] in_data;
  logic              out_ready;
  logic              out_valid;
  logic signed [3:0] out_data;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              locked;
  logic              sync_err;
  logic              ovf;

  int total = 0;
  int bad_n = 0;
  int serr_cnt = 0;
  int ovf_cnt = 0;
  int fr [8];
  int ex [4];

  tiny_ifft #(.IN_W(6), .OUT_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last),
    .locked(locked), .sync_err(sync_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Count status pulses away from the active edge.
  always @(negedge clk) begin
    if (sync_err === 1'b1) serr_cnt++;
    if (ovf === 1'b1) ovf_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int d, input logic sof, input logic re);
    in_valid = 1'b1;
    in_sof   = sof;
    in_re    = re;
    in_data  = 6'(d);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_re    = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 8; i++) send_word(fr[i], i == 0, ~i[0]);
  endtask

  task automatic set_frame1();
    fr = '{10, 0, -2, 2, -2, 0, -2, -2};
    ex = '{1, 2, 3, 4};
  endtask

  task automatic set_frame2();
    fr = '{-2, 0, -8, -8, -14, 0, -8, 8};
    ex = '{-8, 7, 0, -1};
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_sof = 1'b1; in_re = 1'b1; in_data = 6'd5;
    step(); step();
    total++;
    if (out_valid !== 1'b0 || locked !== 1'b0) begin
      bad_n++; $display("FAIL reset_valid_locked: got %b%b want 00", out_valid, locked);
    end
    total++;
    if ({out_data, out_idx, out_last, sync_err, ovf} !== 9'd0) begin
      bad_n++; $display("FAIL reset_outputs: got %b want 0", {out_data, out_idx, out_last, sync_err, ovf});
    end
    reset = 1'b0; idle(); step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) set_frame1(); else set_frame2();
      serr_cnt = 0;
      send_frame(); idle();
      total++;
      if (locked !== 1'b1) begin bad_n++; $display("FAIL basic_locked f%0d: got %b want 1", f, locked); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'(ex[i]) || out_idx !== 2'(i) || out_last !== (i == 3)) begin
          bad_n++;
          $display("FAIL basic f%0d s%0d: got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b", f, i, out_valid, out_data, out_idx, out_last, ex[i], i, i == 3);
        end
        step();
      end
      total++;
      if (out_valid !== 1'b0 || serr_cnt != 0) begin
        bad_n++; $display("FAIL basic_end f%0d: got v=%b serr=%0d want v=0 serr=0", f, out_valid, serr_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_frame1(); send_frame();
    set_frame2(); ovf_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send_word(fr[i], i == 0, ~i[0]);
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'sd1 || out_idx !== 2'd0) begin
        bad_n++; $display("FAIL b2b_hold w%0d: got v=%b d=%0d i=%0d want v=1 d=1 i=0", i, out_valid, out_data, out_idx);
      end
    end
    idle(); step();
    total++;
    if (ovf_cnt != 1) begin bad_n++; $display("FAIL b2b_ovf: got %0d pulses want 1", ovf_cnt); end
    out_ready = 1'b1; set_frame1();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'(ex[i]) || out_idx !== 2'(i)) begin
        bad_n++; $display("FAIL b2b_drain s%0d: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d", i, out_valid, out_data, out_idx, ex[i], i);
      end
      step();
    end
    step(); step(); step();
    total++;
    if (out_valid !== 1'b0) begin bad_n++; $display("FAIL b2b_only_first: got v=%b want 0", out_valid); end
  endtask

  task automatic test_reload();
    out_ready = 1'b1; ovf_cnt = 0;
    set_frame1(); send_frame();
    set_frame2();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(fr[i], i == 0, ~i[0]);
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) send_word(fr[i], 1'b0, ~i[0]);
    idle();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'(ex[i]) || out_idx !== 2'(i)) begin
        bad_n++; $display("FAIL reload s%0d: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d", i, out_valid, out_data, out_idx, ex[i], i);
      end
      step();
    end
    total++;
    if (ovf_cnt != 0 || out_valid !== 1'b0) begin
      bad_n++; $display("FAIL reload_end: got ovf=%0d v=%b want ovf=0 v=0", ovf_cnt, out_valid);
    end
  endtask

  task automatic test_sof_restart();
    out_ready = 1'b1; serr_cnt = 0;
    set_frame1();
    for (int i = 0; i < 3; i++) send_word(fr[i], i == 0, ~i[0]);
    set_frame2(); send_frame(); idle();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'(ex[i]) || out_idx !== 2'(i)) begin
        bad_n++; $display("FAIL restart s%0d: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d", i, out_valid, out_data, out_idx, ex[i], i);
      end
      step();
    end
    total++;
    if (serr_cnt != 1 || locked !== 1'b1) begin
      bad_n++; $display("FAIL restart_serr: got serr=%0d locked=%b want serr=1 locked=1", serr_cnt, locked);
    end
  endtask

  task automatic test_re_error();
    int vcnt;
    out_ready = 1'b1; serr_cnt = 0; vcnt = 0;
    set_frame1();
    for (int i = 0; i < 5; i++) send_word(fr[i], i == 0, ~i[0]);
    send_word(fr[5], 1'b0, 1'b1);
    total++;
    if (locked !== 1'b0) begin bad_n++; $display("FAIL re_err_locked: got %b want 0", locked); end
    send_word(fr[6], 1'b0, 1'b1);
    send_word(fr[7], 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) vcnt++;
      step();
    end
    total++;
    if (serr_cnt != 1 || vcnt != 0) begin
      bad_n++; $display("FAIL re_err: got serr=%0d valid_cycles=%0d want serr=1 valid_cycles=0", serr_cnt, vcnt);
    end
    send_frame(); idle();
    total++;
    if (locked !== 1'b1 || out_valid !== 1'b1 || out_data !== 4'sd1) begin
      bad_n++; $display("FAIL re_err_relock: got l=%b v=%b d=%0d want l=1 v=1 d=1", locked, out_valid, out_data);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_reset_mid();
    int vcnt;
    out_ready = 1'b1; vcnt = 0;
    set_frame1(); send_frame(); idle();
    step();
    total++;
    if (out_data !== 4'sd2 || out_idx !== 2'd1) begin
      bad_n++; $display("FAIL rst_pre: got d=%0d i=%0d want d=2 i=1", out_data, out_idx);
    end
    reset = 1'b1; step(); reset = 1'b0;
    total++;
    if (out_valid !== 1'b0 || locked !== 1'b0) begin
      bad_n++; $display("FAIL rst_drain: got v=%b l=%b want v=0 l=0", out_valid, locked);
    end
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) vcnt++;
      step();
    end
    for (int i = 0; i < 6; i++) send_word(fr[i], i == 0, ~i[0]);
    idle(); reset = 1'b1; step(); reset = 1'b0;
    send_word(fr[6], 1'b0, 1'b1);
    send_word(fr[7], 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) vcnt++;
      step();
    end
    total++;
    if (vcnt != 0 || locked !== 1'b0) begin
      bad_n++; $display("FAIL rst_no_output: got valid_cycles=%0d l=%b want 0 0", vcnt, locked);
    end
  endtask

  task automatic test_check_en();
    int want_serr;
`ifdef TINY_IFFT_CHECK_EN
    want_serr = 1;
`else
    want_serr = 0;
`endif
    out_ready = 1'b1; serr_cnt = 0;
    fr = '{10, 1, -2, 2, -2, 0, -2, -2};
    ex = '{1, 2, 3, 4};
    send_frame(); idle();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 4'(ex[i])) begin
        bad_n++; $display("FAIL check_en s%0d: got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, ex[i]);
      end
      step();
    end
    total++;
    if (serr_cnt != want_serr || locked !== 1'b1) begin
      bad_n++; $display("FAIL check_en_serr: got serr=%0d l=%b want serr=%0d l=1", serr_cnt, locked, want_serr);
    end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; idle();
    test_reset();
    test_basic();
    test_back_to_back();
    test_reload();
    test_sof_restart();
    test_re_error();
    test_reset_mid();
    test_check_en();
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

endmodule

// File: doc/tiny_ifft.md
Name: tiny_ifft

Overview:
- 4-point inverse FFT receiver. Consumes the serialized spectrum stream produced by the team's 4-point forward FFT: 8 words per frame, a start-of-frame flag and a real/imag flag.
- Locks to frame boundaries, captures one frame and computes the inverse DFT with the 1/4 scaling applied.
- Streams the 4 reconstructed signed time samples out under a valid/ready handshake.
- Sits on the far side of the FFT output pins for loopback and self-test.

Parameters:
- IN_W, 6, signed spectrum word width.
- OUT_W, 4, signed output sample width. The result is truncated to this width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word present this cycle; tie high for a free-running source
- in_sof  in  1  high on word 0 of a frame
- in_re  in  1  high on real words (even word index)
- in_data  in  IN_W  signed spectrum word
- out_ready  in  1  sink accepts out_data
- out_valid  out  1  out_data holds a sample
- out_data  out  OUT_W  signed time sample x[out_idx]
- out_idx  out  2  sample index 0..3
- out_last  out  1  high with sample 3
- locked  out  1  frame sync acquired
- sync_err  out  1  one-cycle pulse on framing violation
- ovf  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset value of all outputs is 0. Reset also clears the state, the word counter and the output buffer. Reset mid-frame or mid-drain discards everything; the frame in flight is never emitted.
- Frame word order (index 0..7): X0r, X0i, X1r, X1i, X2r, X2i, X3r, X3i. in_re must equal the inverse of index bit 0.
- Words are accepted only on cycles with in_valid high. Gaps are allowed anywhere.
- States: HUNT and CAPTURE.
- HUNT:
  - in_valid & in_sof: store word 0, set cnt=1, go to CAPTURE, set locked=1.
  - Any other word is ignored.
- CAPTURE, on an accepted word:
  - If in_sof & cnt!=0: pulse sync_err and restart the frame with this word as word 0 (cnt=1).
  - Else if in_re != ~cnt[0], or cnt==0 without in_sof: pulse sync_err, set locked=0, go to HUNT. The word is discarded.
  - Else store the word, then cnt <= cnt+1 (3-bit wrap).
  - On storing word 7 (cnt==7): frame complete; stay in CAPTURE with cnt=0, expecting sof next.
- Inverse transform, evaluated on frame complete. Operands are sign-extended to IN_W+2 bits:
  - s0 = X0r+X2r+X1r+X3r
  - s1 = X0r-X2r-X1i+X3i
  - s2 = X0r+X2r-X1r-X3r
  - s3 = X0r-X2r+X1i-X3i
  - x[n] = s_n arithmetic-shifted right by 2, then the low OUT_W bits.
  - X0i and X2i are captured but unused.
- Output buffer: 4 samples plus a busy flag.
  - On frame complete with the buffer empty: load all 4 samples at that edge. out_valid=1, out_idx=0 on the next cycle, i.e. latency 1 cycle after word 7 is accepted.
  - On frame complete with the buffer busy: drop the frame and pulse ovf. The buffer is untouched.
- Handshake:
  - out_data, out_idx and out_last are held stable while out_valid & ~out_ready.
  - A transfer occurs on out_valid & out_ready, then out_idx increments.
  - A transfer with out_last frees the buffer.
  - A frame completing in the same cycle as the last transfer is accepted: buffer reloads, out_valid stays 1, out_idx=0, no ovf.
- Capture never stalls. The input side has no backpressure.

Optional Feature:
- TINY_IFFT_CHECK_EN defined: on frame complete, also check all of:
  - X0i==0 and X2i==0
  - X1r==X3r and X1i==-X3i
  - s0..s3 low 2 bits all zero
- On any failure: pulse sync_err, still emit the samples, locked unaffected.
- Without the macro: no consistency check; sync_err covers framing only.

Test Plan:
- Reset, out_ready=1, frame 10,0,-2,2,-2,0,-2,-2 with sof on the first word -> out_data 1,2,3,4, out_idx 0..3, out_last on 4, out_valid one cycle after the last word, locked=1.
- Frame -2,0,-8,-8,-14,0,-8,8 -> -8,7,0,-1.
- Back-to-back frames, out_ready=0 throughout the second -> first frame's sample 0 held stable, ovf pulses once at second frame's word 7. Then out_ready=1 -> drains the first frame only.
- Framing errors:
  - sof asserted at word 3 -> sync_err pulse, capture restarts, the following 7 words produce a correct frame.
  - in_re wrong at word 5 -> sync_err, locked=0, no output until the next sof.
- Reset asserted mid-drain (after sample 1) -> out_valid=0 next cycle, locked=0, no further samples.
- With TINY_IFFT_CHECK_EN: frame 10,1,-2,2,-2,0,-2,-2 -> sync_err pulse, samples still emitted. Without the macro: no sync_err.
